// File: rtl/clk_div_pkg.sv
// Shared types and elaboration-time helpers for the programmable clock divider bank.
package clk_div_pkg;

   localparam int HALF_W = 32;

   typedef logic [HALF_W-1:0] half_t;

   // Channel-select width, never narrower than one bit so a single-channel bank still has a port.
   function automatic int ch_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Reset half-period giving a 1 Hz output at the given system clock rate.
   function automatic half_t def_half(input int unsigned clk_hz);
      return half_t'(clk_hz / 2);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter with a shadowed reload that only takes effect
// at a terminal count, a sync realign or while the channel is stopped.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int            CW       = 32,
   parameter logic [CW-1:0] DEF_HALF = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          sync,
   input  logic          we,
   input  logic [CW-1:0] wdata,
   output logic          nclk,
   output logic          tick
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] half_q, half_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic          nclk_q, nclk_d;
   logic          tick_q, tick_d;
   logic          terminal;

   always_comb begin
      shadow_d = we ? wdata : shadow_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      nclk_d   = nclk_q;
      tick_d   = 1'b0;
      terminal = (half_q != '0) && (cnt_q == half_q - CW'(1));

      if (sync) begin
         // A write in the same cycle as sync is the value that gets loaded.
         cnt_d  = '0;
         nclk_d = 1'b0;
         half_d = we ? wdata : shadow_q;
      end else if (en) begin
         if (half_q == '0) begin
            half_d = shadow_q;
         end else if (terminal) begin
            cnt_d  = '0;
            nclk_d = ~nclk_q;
            tick_d = 1'b1;
            half_d = shadow_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         half_q   <= DEF_HALF;
         shadow_q <= DEF_HALF;
         nclk_q   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         shadow_q <= shadow_d;
         nclk_q   <= nclk_d;
         tick_q   <= tick_d;
      end
   end

   assign nclk = nclk_q;
   assign tick = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable dividers sharing enable, sync and a config write port.
// Consume tick as a clock enable on clk; nclk is for pins and LEDs only.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int    CLK_HZ   = 100_000_000,
   parameter int    NCH      = 4,
   parameter int    CW       = 32,
   parameter half_t DEF_HALF = def_half(CLK_HZ),
   localparam int   CHW      = ch_w(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           sync,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_half,
   output logic [NCH-1:0] nclk,
   output logic [NCH-1:0] tick
);

   // Addresses at or above NCH match no channel, so such writes are dropped.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic we;

      assign we = cfg_we && (cfg_ch == CHW'(gi));

      clk_div_chan #(
         .CW       (CW),
         .DEF_HALF (CW'(DEF_HALF))
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .sync  (sync),
         .we    (we),
         .wdata (cfg_half),
         .nclk  (nclk[gi]),
         .tick  (tick[gi])
      );
   end

endmodule
